// File: rtl/mult_rr_scheduler_pkg.sv
// mult_rr_scheduler_pkg: shared sizing helpers for the round-robin multiplier scheduler
package mult_rr_scheduler_pkg;
  function automatic int clog2min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/mult_rr_scheduler_if.sv
// mult_rr_scheduler_if: requester operand handshakes plus the tagged result handshake
interface mult_rr_scheduler_if #(parameter int N = 4, parameter int NREQ = 4);
  import mult_rr_scheduler_pkg::*;
  localparam int IDW = clog2min1(NREQ);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic res_valid;
  logic res_ready;
  logic [2*N-1:0] res_p;
  logic [IDW-1:0] res_id;
  modport master (
    output req_valid, req_a, req_b, res_ready,
    input req_ready, res_valid, res_p, res_id
  );
  modport slave (
    input req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_p, res_id
  );
endinterface

// File: rtl/mult_rr_scheduler_multiplier.sv
// multiplier_carrysave: unsigned NxN array multiplier, carry-save rows with one final adder
module multiplier_carrysave #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [2*N-1:0] p
);
  logic [2*N-1:0] s [N+1];
  logic [2*N-1:0] c [N+1];
  assign s[0] = '0;
  assign c[0] = '0;
  for (genvar i = 0; i < N; i++) begin : g_row
    logic [2*N-1:0] pp;
    assign pp = b[i] ? ({{N{1'b0}}, a} << i) : '0;
    assign s[i+1] = s[i] ^ c[i] ^ pp;
    // carries dropped off the top are zero because the true product fits in 2N bits
    assign c[i+1] = ((s[i] & c[i]) | (s[i] & pp) | (c[i] & pp)) << 1;
  end
  assign p = s[N] + c[N];
endmodule

// File: rtl/mult_rr_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin grant starting at ptr; ptr moves past the winner on each transfer
module rr_arbiter
  import mult_rr_scheduler_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDW = clog2min1(NREQ)
) (
  input  logic clk,
  input  logic rst,
  input  logic [NREQ-1:0] req,
  input  logic advance,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0] gid
);
  logic [IDW-1:0] ptr;
  logic found;
  always_comb begin
    gid = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        gid = IDW'((int'(ptr) + k) % NREQ);
      end
    end
    grant = found ? (NREQ'(1) << gid) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (advance) ptr <= (int'(gid) == NREQ - 1) ? '0 : gid + 1'b1;
  end
endmodule

// File: rtl/mult_rr_scheduler.sv
// mult_rr_scheduler: shares one multiplier among NREQ requesters through a stallable
// operand/result pipeline, returning each product tagged with its requester id.
module mult_rr_scheduler
  import mult_rr_scheduler_pkg::*;
#(
  parameter int N = 4,
  parameter int NREQ = 4
) (
  input  logic clk,
  input  logic rst,
  mult_rr_scheduler_if.slave bus,
  output logic busy
);
  localparam int IDW = clog2min1(NREQ);
  logic [NREQ-1:0] grant;
  logic [IDW-1:0] gid, s1_id, s2_id;
  logic [N-1:0] s1_a, s1_b;
  logic [2*N-1:0] prod, s2_p;
  logic s1_vld, s2_vld, s1_free, s2_free, xfer;
  assign s2_free = !s2_vld || bus.res_ready;
  assign s1_free = !s1_vld || s2_free;
  assign bus.req_ready = rst ? '0 : grant & {NREQ{s1_free}};
  assign xfer = |bus.req_ready;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk(clk),
    .rst(rst),
    .req(bus.req_valid),
    .advance(xfer),
    .grant(grant),
    .gid(gid)
  );
  multiplier_carrysave #(.N(N)) u_mul (
    .a(s1_a),
    .b(s1_b),
    .p(prod)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
      s1_id <= '0;
      s2_vld <= 1'b0;
      s2_p <= '0;
      s2_id <= '0;
    end else begin
      if (s1_free) begin
        s1_vld <= xfer;
        if (xfer) begin
          s1_a <= bus.req_a[gid*N +: N];
          s1_b <= bus.req_b[gid*N +: N];
          s1_id <= gid;
        end
      end
      if (s2_free) begin
        s2_vld <= s1_vld;
        if (s1_vld) begin
          s2_p <= prod;
          s2_id <= s1_id;
        end
      end
    end
  end
  assign bus.res_valid = s2_vld;
  assign bus.res_p = s2_p;
  assign bus.res_id = s2_id;
  assign busy = s1_vld || s2_vld;
endmodule

// File: tb/tb_mult_rr_scheduler.sv
// tb_mult_rr_scheduler: directed scenarios with hand-computed grants and products
module tb_mult_rr_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int total = 0;
  int bad = 0;
  mult_rr_scheduler_if #(.N(4), .NREQ(4)) bus ();
  mult_rr_scheduler #(.N(4), .NREQ(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .busy(busy)
  );
  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b);
    bus.req_valid[i] = 1'b1;
    bus.req_a[i*4 +: 4] = a;
    bus.req_b[i*4 +: 4] = b;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.res_ready = 1'b1;
    bus.req_valid = 4'b0001;
    bus.req_a = '0;
    bus.req_b = '0;
    repeat (2) @(negedge clk);
    total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b exp=0", bus.res_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready); end
    total++; if (bus.res_p !== 8'd0 || bus.res_id !== 2'd0) begin bad++; $display("FAIL reset_res got p=%0d id=%0d exp p=0 id=0", bus.res_p, bus.res_id); end
    bus.req_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    set_req(0, 4'd3, 4'd5);
    #1;
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready got=%b exp=0001", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = '0;
    total++; if (bus.res_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL single_s1 got rv=%b busy=%b exp rv=0 busy=1", bus.res_valid, busy); end
    @(negedge clk);
    total++; if (bus.res_valid !== 1'b1 || bus.res_p !== 8'd15 || bus.res_id !== 2'd0) begin bad++; $display("FAIL single_res got rv=%b p=%0d id=%0d exp rv=1 p=15 id=0", bus.res_valid, bus.res_p, bus.res_id); end
    @(negedge clk);
    total++; if (bus.res_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_idle got rv=%b busy=%b exp 0 0", bus.res_valid, busy); end
  endtask

  task automatic test_all_four();
    logic [3:0] exp_rdy [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    logic [7:0] exp_p [4] = '{8'd2, 8'd12, 8'd30, 8'd56};
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 4'd1, 4'd2);
    set_req(1, 4'd3, 4'd4);
    set_req(2, 4'd5, 4'd6);
    set_req(3, 4'd7, 4'd8);
    for (int n = 0; n < 7; n++) begin
      if (n >= 2 && n <= 5) begin
        total++; if (bus.res_valid !== 1'b1 || bus.res_p !== exp_p[n-2] || int'(bus.res_id) != n - 2) begin bad++; $display("FAIL all4_res%0d got rv=%b p=%0d id=%0d exp rv=1 p=%0d id=%0d", n - 2, bus.res_valid, bus.res_p, bus.res_id, exp_p[n-2], n - 2); end
      end else if (n == 6) begin
        total++; if (bus.res_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL all4_idle got rv=%b busy=%b exp 0 0", bus.res_valid, busy); end
      end
      if (n >= 1 && n <= 4) bus.req_valid[n-1] = 1'b0;
      #1;
      total++; if (bus.req_ready !== exp_rdy[n]) begin bad++; $display("FAIL all4_grant%0d got=%b exp=%b", n, bus.req_ready, exp_rdy[n]); end
      @(negedge clk);
    end
  endtask

  task automatic test_alternate();
    set_req(0, 4'd2, 4'd3);
    set_req(2, 4'd4, 4'd5);
    for (int i = 0; i < 6; i++) begin
      if (i >= 2) begin
        total++; if (bus.res_valid !== 1'b1 || bus.res_p !== ((i % 2 == 1) ? 8'd20 : 8'd6) || bus.res_id !== ((i % 2 == 1) ? 2'd2 : 2'd0)) begin bad++; $display("FAIL alt_res%0d got rv=%b p=%0d id=%0d", i, bus.res_valid, bus.res_p, bus.res_id); end
      end
      #1;
      total++; if (bus.req_ready !== ((i % 2 == 1) ? 4'b0100 : 4'b0001)) begin bad++; $display("FAIL alt_grant%0d got=%b exp=%b", i, bus.req_ready, (i % 2 == 1) ? 4'b0100 : 4'b0001); end
      @(negedge clk);
    end
    bus.req_valid = '0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL alt_drain got busy=%b exp=0", busy); end
  endtask

  task automatic test_backpressure();
    bus.res_ready = 1'b0;
    set_req(0, 4'd2, 4'd7);
    set_req(1, 4'd3, 4'd3);
    set_req(2, 4'd6, 4'd5);
    #1;
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL bp_grant0 got=%b exp=0001", bus.req_ready); end
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    #1;
    total++; if (bus.req_ready !== 4'b0010 || bus.res_valid !== 1'b0) begin bad++; $display("FAIL bp_grant1 got rdy=%b rv=%b exp 0010 0", bus.req_ready, bus.res_valid); end
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    #1;
    total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL bp_full got=%b exp=0000", bus.req_ready); end
    total++; if (bus.res_valid !== 1'b1 || bus.res_p !== 8'd14 || bus.res_id !== 2'd0) begin bad++; $display("FAIL bp_hold0 got rv=%b p=%0d id=%0d exp 1 14 0", bus.res_valid, bus.res_p, bus.res_id); end
    @(negedge clk);
    total++; if (bus.req_ready !== 4'b0000 || bus.res_p !== 8'd14 || bus.res_id !== 2'd0) begin bad++; $display("FAIL bp_hold1 got rdy=%b p=%0d id=%0d exp 0000 14 0", bus.req_ready, bus.res_p, bus.res_id); end
    bus.res_ready = 1'b1;
    #1;
    total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL bp_release got=%b exp=0100", bus.req_ready); end
    @(negedge clk);
    bus.req_valid[2] = 1'b0;
    total++; if (bus.res_valid !== 1'b1 || bus.res_p !== 8'd9 || bus.res_id !== 2'd1) begin bad++; $display("FAIL bp_res1 got rv=%b p=%0d id=%0d exp 1 9 1", bus.res_valid, bus.res_p, bus.res_id); end
    @(negedge clk);
    total++; if (bus.res_valid !== 1'b1 || bus.res_p !== 8'd30 || bus.res_id !== 2'd2) begin bad++; $display("FAIL bp_res2 got rv=%b p=%0d id=%0d exp 1 30 2", bus.res_valid, bus.res_p, bus.res_id); end
    @(negedge clk);
    total++; if (bus.res_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL bp_once got rv=%b busy=%b exp 0 0", bus.res_valid, busy); end
  endtask

  task automatic test_extremes();
    set_req(3, 4'd15, 4'd15);
    set_req(1, 4'd0, 4'd15);
    #1;
    total++; if (bus.req_ready !== 4'b1000) begin bad++; $display("FAIL ext_grant3 got=%b exp=1000", bus.req_ready); end
    @(negedge clk);
    bus.req_valid[3] = 1'b0;
    #1;
    total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL ext_grant1 got=%b exp=0010", bus.req_ready); end
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    total++; if (bus.res_valid !== 1'b1 || bus.res_p !== 8'd225 || bus.res_id !== 2'd3) begin bad++; $display("FAIL ext_max got rv=%b p=%0d id=%0d exp 1 225 3", bus.res_valid, bus.res_p, bus.res_id); end
    @(negedge clk);
    total++; if (bus.res_valid !== 1'b1 || bus.res_p !== 8'd0 || bus.res_id !== 2'd1) begin bad++; $display("FAIL ext_zero got rv=%b p=%0d id=%0d exp 1 0 1", bus.res_valid, bus.res_p, bus.res_id); end
    @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    bus.res_ready = 1'b0;
    set_req(2, 4'd1, 4'd1);
    set_req(3, 4'd2, 4'd2);
    @(negedge clk);
    bus.req_valid[2] = 1'b0;
    @(negedge clk);
    bus.req_valid[3] = 1'b0;
    total++; if (busy !== 1'b1 || bus.res_valid !== 1'b1 || bus.res_p !== 8'd1) begin bad++; $display("FAIL mid_full got busy=%b rv=%b p=%0d exp 1 1 1", busy, bus.res_valid, bus.res_p); end
    set_req(1, 4'd1, 4'd3);
    set_req(3, 4'd3, 4'd3);
    rst = 1'b1;
    #1;
    total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL mid_rst_ready got=%b exp=0000", bus.req_ready); end
    @(negedge clk);
    rst = 1'b0;
    total++; if (bus.res_valid !== 1'b0 || busy !== 1'b0 || bus.res_p !== 8'd0) begin bad++; $display("FAIL mid_cleared got rv=%b busy=%b p=%0d exp 0 0 0", bus.res_valid, busy, bus.res_p); end
    bus.res_ready = 1'b1;
    #1;
    total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL mid_lowest got=%b exp=0010", bus.req_ready); end
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL mid_stale got rv=%b exp=0", bus.res_valid); end
    #1;
    total++; if (bus.req_ready !== 4'b1000) begin bad++; $display("FAIL mid_next got=%b exp=1000", bus.req_ready); end
    @(negedge clk);
    bus.req_valid[3] = 1'b0;
    total++; if (bus.res_valid !== 1'b1 || bus.res_p !== 8'd3 || bus.res_id !== 2'd1) begin bad++; $display("FAIL mid_res1 got rv=%b p=%0d id=%0d exp 1 3 1", bus.res_valid, bus.res_p, bus.res_id); end
    @(negedge clk);
    total++; if (bus.res_valid !== 1'b1 || bus.res_p !== 8'd9 || bus.res_id !== 2'd3) begin bad++; $display("FAIL mid_res3 got rv=%b p=%0d id=%0d exp 1 9 3", bus.res_valid, bus.res_p, bus.res_id); end
    @(negedge clk);
    total++; if (bus.res_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_idle got rv=%b busy=%b exp 0 0", bus.res_valid, busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_alternate();
    test_backpressure();
    test_extremes();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
